// File: rtl/mips_pkg.sv
// Shared opcode/funct constants, FSM and ALU enums for mips_mc_cpu.
// The immediate-op constants serve the MIPS_MC_IMM_OPS_EN build.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    S_IDLE, S_DEC, S_EX, S_MEM, S_WB
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR,
    ALU_NOR, ALU_SLT, ALU_BAD
  } alu_op_e;

  // Callers recast through $signed so any DATA_W >= 16 extends correctly.
  function automatic logic [63:0] sext16(input logic [15:0] v);
    return {{48{v[15]}}, v};
  endfunction

endpackage

// File: rtl/mips_mc_regfile.sv
// Register file: two async read ports, one sync write port.
// Async clear; r0 reads 0 and ignores writes.
module mips_mc_regfile #(
  parameter int DATA_W = 32,
  parameter int REG_N  = 32,
  localparam int RW = $clog2(REG_N)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [RW-1:0]     ra1_i,
  input  logic [RW-1:0]     ra2_i,
  output logic [DATA_W-1:0] rd1_o,
  output logic [DATA_W-1:0] rd2_o,
  input  logic              we_i,
  input  logic [RW-1:0]     wa_i,
  input  logic [DATA_W-1:0] wd_i
);

  logic [DATA_W-1:0] register [REG_N];

  // Clear on reset; commit writes except to r0.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < REG_N; i++)
        register[i] <= '0;
    end else if (we_i && wa_i != '0) begin
      register[wa_i] <= wd_i;
    end
  end

  assign rd1_o = (ra1_i == '0) ? '0 : register[ra1_i];
  assign rd2_o = (ra2_i == '0) ? '0 : register[ra2_i];

endmodule

// File: rtl/mips_mc_cpu.sv
// Multi-cycle MIPS core: IDLE/DEC/EX/MEM/WB with busy/done handshake.
// Define MIPS_MC_IMM_OPS_EN to add addi/andi/ori.
module mips_mc_cpu
  import mips_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_N      = 32,
  parameter int DMEM_DEPTH = 256
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [31:0]       instrWord,
  input  logic              newInstr,
  output logic              busy,
  output logic              done,
  output logic              invalid,
  output logic [DATA_W-1:0] ALUResult
);

  localparam int RW = $clog2(REG_N);
  localparam int AW = $clog2(DMEM_DEPTH);

  state_e            state_q, state_d;
  logic [31:0]       ir_q;
  logic [DATA_W-1:0] a_q, b_q, alu_q, mdr_q;
  logic              done_q, done_d;
  logic              inv_q, inv_d;

  logic [DATA_W-1:0] dmem [DMEM_DEPTH];

  logic [5:0]        opcode, funct;
  logic [RW-1:0]     rs, rt, rd;
  alu_op_e           op;
  logic              is_mem, is_st, use_imm, zext;
  logic              wr_rt, wr_rd, bad;
  logic [DATA_W-1:0] imm_s, imm_z, opb, alu_d;
  logic [DATA_W-1:0] rd1, rd2;
  logic [AW-1:0]     widx;
  logic              unused_ir;

  assign opcode = ir_q[31:26];
  assign funct  = ir_q[5:0];
  assign rs     = ir_q[21 +: RW];
  assign rt     = ir_q[16 +: RW];
  assign rd     = ir_q[11 +: RW];
  assign imm_s  = DATA_W'($signed(sext16(ir_q[15:0])));
  assign imm_z  = DATA_W'(ir_q[15:0]);
  assign widx   = alu_q[AW+1:2];
  assign unused_ir = ^ir_q[10:6];

  // Decode the latched IR into ALU op and datapath controls.
  always_comb begin
    op      = ALU_BAD;
    is_mem  = 1'b0;
    is_st   = 1'b0;
    use_imm = 1'b0;
    zext    = 1'b0;
    wr_rt   = 1'b0;
    wr_rd   = 1'b0;
    unique case (1'b1)
      opcode == OP_RTYPE: begin
        unique case (1'b1)
          funct == FN_ADD: op = ALU_ADD;
          funct == FN_SUB: op = ALU_SUB;
          funct == FN_AND: op = ALU_AND;
          funct == FN_OR:  op = ALU_OR;
          funct == FN_NOR: op = ALU_NOR;
          funct == FN_SLT: op = ALU_SLT;
          default:         op = ALU_BAD;
        endcase
        wr_rd = (op != ALU_BAD);
      end
      opcode == OP_LW: begin
        op      = ALU_ADD;
        is_mem  = 1'b1;
        use_imm = 1'b1;
        wr_rt   = 1'b1;
      end
      opcode == OP_SW: begin
        op      = ALU_ADD;
        is_mem  = 1'b1;
        is_st   = 1'b1;
        use_imm = 1'b1;
      end
`ifdef MIPS_MC_IMM_OPS_EN
      opcode == OP_ADDI: begin
        op      = ALU_ADD;
        use_imm = 1'b1;
        wr_rt   = 1'b1;
      end
      opcode == OP_ANDI: begin
        op      = ALU_AND;
        use_imm = 1'b1;
        zext    = 1'b1;
        wr_rt   = 1'b1;
      end
      opcode == OP_ORI: begin
        op      = ALU_OR;
        use_imm = 1'b1;
        zext    = 1'b1;
        wr_rt   = 1'b1;
      end
`endif
      default: ;
    endcase
    bad = (op == ALU_BAD);
  end

  // Inline ALU; unsupported ops leave the result untouched.
  always_comb begin
    opb   = use_imm ? (zext ? imm_z : imm_s) : b_q;
    alu_d = alu_q;
    unique case (op)
      ALU_ADD: alu_d = a_q + opb;
      ALU_SUB: alu_d = a_q - opb;
      ALU_AND: alu_d = a_q & opb;
      ALU_OR:  alu_d = a_q | opb;
      ALU_NOR: alu_d = ~(a_q | opb);
      ALU_SLT: alu_d = DATA_W'($signed(a_q) < $signed(opb));
      default: alu_d = alu_q;
    endcase
  end

  mips_mc_regfile #(
    .DATA_W (DATA_W),
    .REG_N  (REG_N)
  ) myReg (
    .Clk   (Clk),
    .Reset (Reset),
    .ra1_i (rs),
    .ra2_i (rt),
    .rd1_o (rd1),
    .rd2_o (rd2),
    .we_i  (state_q == S_WB && (wr_rt || wr_rd)),
    .wa_i  (wr_rd ? rd : rt),
    .wd_i  (is_mem ? mdr_q : alu_q)
  );

  // Next state plus the retire pulses issued on leaving WB.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    inv_d   = 1'b0;
    unique case (state_q)
      S_IDLE: if (newInstr) state_d = S_DEC;
      S_DEC:  state_d = S_EX;
      S_EX:   state_d = is_mem ? S_MEM : S_WB;
      S_MEM:  state_d = S_WB;
      S_WB: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        inv_d   = bad;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, IR, operand, result and load-data registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      alu_q   <= '0;
      mdr_q   <= '0;
      done_q  <= 1'b0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      inv_q   <= inv_d;
      if (state_q == S_IDLE && newInstr)
        ir_q <= instrWord;
      if (state_q == S_DEC) begin
        a_q <= rd1;
        b_q <= rd2;
      end
      if (state_q == S_EX && !bad)
        alu_q <= alu_d;
      if (state_q == S_MEM && !is_st)
        mdr_q <= dmem[widx];
    end
  end

  // Store port: no reset, contents are preloaded externally.
  always_ff @(posedge Clk) begin
    if (state_q == S_MEM && is_st)
      dmem[widx] <= b_q;
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign invalid   = inv_q;
  assign ALUResult = alu_q;

endmodule

// File: tb/tb_mips_mc_cpu.sv
// Self-checking bench for mips_mc_cpu against an instruction-level model.
// Mirrors MIPS_MC_IMM_OPS_EN when that macro is defined for the build.
module tb_mips_mc_cpu;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] instrWord;
  logic        newInstr;
  logic        busy, done, invalid;
  logic [31:0] ALUResult;

  int total = 0;
  int bad   = 0;

  logic [31:0] mregs [32];
  logic [31:0] mmem  [256];
  logic [31:0] malu;

  always #5 Clk = ~Clk;

  mips_mc_cpu dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .instrWord (instrWord),
    .newInstr  (newInstr),
    .busy      (busy),
    .done      (done),
    .invalid   (invalid),
    .ALUResult (ALUResult)
  );

  // Instruction-level reference: whole-instruction effect, edge count to done.
  task automatic model(input logic [31:0] ins, output int lat, output bit inv);
    logic [5:0]  op, fn;
    logic [4:0]  rt, rd;
    logic [31:0] a, b, r, se, addr;
    op = ins[31:26];
    fn = ins[5:0];
    rt = ins[20:16];
    rd = ins[15:11];
    a  = mregs[ins[25:21]];
    b  = mregs[rt];
    se = {{16{ins[15]}}, ins[15:0]};
    r  = 32'h0;
    lat = 3;
    inv = 1'b0;
    if (op == 6'h00) begin
      case (fn)
        6'h20: r = a + b;
        6'h22: r = a - b;
        6'h24: r = a & b;
        6'h25: r = a | b;
        6'h27: r = ~(a | b);
        6'h2A: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        default: inv = 1'b1;
      endcase
      if (!inv) begin
        malu = r;
        if (rd != 0) mregs[rd] = r;
      end
    end else if (op == 6'h23) begin
      addr = a + se;
      malu = addr;
      lat = 4;
      if (rt != 0) mregs[rt] = mmem[addr[9:2]];
    end else if (op == 6'h2B) begin
      addr = a + se;
      malu = addr;
      lat = 4;
      mmem[addr[9:2]] = b;
    end
`ifdef MIPS_MC_IMM_OPS_EN
    else if (op == 6'h08 || op == 6'h0C || op == 6'h0D) begin
      if (op == 6'h08) r = a + se;
      else if (op == 6'h0C) r = a & {16'h0, ins[15:0]};
      else r = a | {16'h0, ins[15:0]};
      malu = r;
      if (rt != 0) mregs[rt] = r;
    end
`endif
    else begin
      inv = 1'b1;
    end
  endtask

  // Issue one instruction from IDLE; returns edges from acceptance to done.
  task automatic run_instr(input logic [31:0] ins, output int lat,
                           output bit inv);
    instrWord = ins;
    newInstr  = 1'b1;
    @(posedge Clk);
    #1 newInstr = 1'b0;
    lat = 0;
    inv = 1'b0;
    while (lat < 20) begin
      @(posedge Clk);
      lat++;
      #1;
      if (done) begin
        inv = invalid;
        break;
      end
    end
  endtask

  function automatic int reg_diffs();
    int n = 0;
    for (int i = 0; i < 32; i++)
      if (dut.myReg.register[i] !== mregs[i]) n++;
    return n;
  endfunction

  function automatic int mem_diffs();
    int n = 0;
    for (int i = 0; i < 256; i++)
      if (dut.dmem[i] !== mmem[i]) n++;
    return n;
  endfunction

  task automatic test_reset();
    Reset = 1'b1;
    newInstr = 1'b0;
    instrWord = 32'h0;
    for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
    malu = 32'h0;
    repeat (2) @(posedge Clk);
    #1;
    for (int i = 0; i < 256; i++) begin
      dut.dmem[i] = 32'h0;
      mmem[i] = 32'h0;
    end
    total++;
    if ({busy, done, invalid} !== 3'b000) begin
      bad++;
      $display("FAIL reset_flags got=%b want=000", {busy, done, invalid});
    end
    total++;
    if (ALUResult !== 32'h0) begin
      bad++;
      $display("FAIL reset_alu got=%h want=0", ALUResult);
    end
    total++;
    if (reg_diffs() !== 0) begin
      bad++;
      $display("FAIL reset_regs diffs=%0d want=0", reg_diffs());
    end
    @(negedge Clk);
    Reset = 1'b0;
    @(posedge Clk);
    #1;
  endtask

  task automatic test_lw();
    int lat, el;
    bit inv, ei;
    dut.dmem[0] = 32'd10; mmem[0] = 32'd10;
    dut.dmem[1] = 32'd22; mmem[1] = 32'd22;
    dut.dmem[2] = 32'd6;  mmem[2] = 32'd6;
    model(32'h8C010000, el, ei);
    run_instr(32'h8C010000, lat, inv);
    total++;
    if (lat !== 4) begin
      bad++;
      $display("FAIL lw_latency got=%0d want=4", lat);
    end
    total++;
    if (dut.myReg.register[1] !== 32'd10 || ALUResult !== 32'h0) begin
      bad++;
      $display("FAIL lw_r1 got r1=%h alu=%h want r1=a alu=0",
               dut.myReg.register[1], ALUResult);
    end
    model(32'h8C020004, el, ei);
    run_instr(32'h8C020004, lat, inv);
    total++;
    if (reg_diffs() !== 0 || ALUResult !== malu) begin
      bad++;
      $display("FAIL lw_r2 diffs=%0d alu=%h want alu=%h",
               reg_diffs(), ALUResult, malu);
    end
  endtask

  task automatic test_rtype();
    int lat, el;
    bit inv, ei;
    model(32'h00221822, el, ei);
    run_instr(32'h00221822, lat, inv);
    total++;
    if (lat !== 3 || dut.myReg.register[3] !== 32'hFFFFFFF4) begin
      bad++;
      $display("FAIL sub got lat=%0d r3=%h want lat=3 r3=fffffff4",
               lat, dut.myReg.register[3]);
    end
    model(32'h0022202A, el, ei);
    run_instr(32'h0022202A, lat, inv);
    total++;
    if (lat !== el || dut.myReg.register[4] !== 32'd1) begin
      bad++;
      $display("FAIL slt got lat=%0d r4=%h want lat=%0d r4=1",
               lat, dut.myReg.register[4], el);
    end
    total++;
    if (reg_diffs() !== 0 || ALUResult !== malu) begin
      bad++;
      $display("FAIL rtype_state diffs=%0d alu=%h want alu=%h",
               reg_diffs(), ALUResult, malu);
    end
  endtask

  task automatic test_sw();
    int lat, el;
    bit inv, ei;
    model(32'hAC010008, el, ei);
    run_instr(32'hAC010008, lat, inv);
    total++;
    if (lat !== 4 || dut.dmem[2] !== 32'd10) begin
      bad++;
      $display("FAIL sw got lat=%0d dmem2=%h want lat=4 dmem2=a",
               lat, dut.dmem[2]);
    end
    total++;
    if (reg_diffs() !== 0 || mem_diffs() !== 0) begin
      bad++;
      $display("FAIL sw_state regdiffs=%0d memdiffs=%0d want 0 0",
               reg_diffs(), mem_diffs());
    end
  endtask

  task automatic test_r0_invalid();
    int lat, el;
    bit inv, ei;
    logic [31:0] ins [3];
    ins[0] = 32'h00210020;
    ins[1] = 32'hFC000000;
    ins[2] = 32'h00221803;
    model(ins[0], el, ei);
    run_instr(ins[0], lat, inv);
    total++;
    if (dut.myReg.register[0] !== 32'h0 || ALUResult !== 32'd20) begin
      bad++;
      $display("FAIL add_r0 got r0=%h alu=%h want r0=0 alu=14",
               dut.myReg.register[0], ALUResult);
    end
    for (int k = 1; k < 3; k++) begin
      model(ins[k], el, ei);
      run_instr(ins[k], lat, inv);
      total++;
      if (inv !== 1'b1 || lat !== 3) begin
        bad++;
        $display("FAIL invalid_%0d got inv=%b lat=%0d want inv=1 lat=3",
                 k, inv, lat);
      end
      total++;
      if (ALUResult !== 32'd20 || reg_diffs() !== 0) begin
        bad++;
        $display("FAIL invalid_state_%0d alu=%h diffs=%0d want alu=14",
                 k, ALUResult, reg_diffs());
      end
    end
  endtask

  task automatic test_ignore();
    int el, ndone, first;
    bit ei;
    model(32'h8C020004, el, ei);
    instrWord = 32'h8C020004;
    newInstr = 1'b1;
    @(posedge Clk);
    #1 newInstr = 1'b0;
    @(posedge Clk);
    #1;
    instrWord = 32'h00211820;
    newInstr = 1'b1;
    @(posedge Clk);
    #1 newInstr = 1'b0;
    ndone = 0;
    first = 0;
    for (int e = 3; e <= 12; e++) begin
      @(posedge Clk);
      #1;
      if (done) begin
        ndone++;
        if (first == 0) first = e;
      end
    end
    total++;
    if (ndone !== 1 || first !== 4) begin
      bad++;
      $display("FAIL ignore_new got dones=%0d at=%0d want 1 at 4",
               ndone, first);
    end
    total++;
    if (reg_diffs() !== 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL ignore_state diffs=%0d busy=%b want 0 0",
               reg_diffs(), busy);
    end
  endtask

  task automatic test_back_to_back();
    int el, nd;
    bit ei;
    int at [$];
    for (int k = 0; k < 3; k++) model(32'h00223820, el, ei);
    instrWord = 32'h00223820;
    newInstr = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      @(posedge Clk);
      #1;
      if (done) at.push_back(e);
    end
    newInstr = 1'b0;
    nd = 0;
    for (int e = 13; e <= 20; e++) begin
      @(posedge Clk);
      #1;
      if (done) nd++;
    end
    total++;
    if (at.size() !== 3 || nd !== 0) begin
      bad++;
      $display("FAIL b2b_count got=%0d extra=%0d want 3 0", at.size(), nd);
    end else begin
      total++;
      if (at[0] !== 4 || at[1] !== 8 || at[2] !== 12) begin
        bad++;
        $display("FAIL b2b_spacing got=%0d,%0d,%0d want 4,8,12",
                 at[0], at[1], at[2]);
      end
    end
    total++;
    if (reg_diffs() !== 0 || ALUResult !== malu) begin
      bad++;
      $display("FAIL b2b_state diffs=%0d alu=%h want alu=%h",
               reg_diffs(), ALUResult, malu);
    end
  endtask

  task automatic test_reset_abort();
    int nd;
    instrWord = 32'h8C050008;
    newInstr = 1'b1;
    @(posedge Clk);
    #1 newInstr = 1'b0;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b1;
    for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
    malu = 32'h0;
    #2;
    total++;
    if ({busy, done, invalid} !== 3'b000 || ALUResult !== 32'h0) begin
      bad++;
      $display("FAIL abort_flags got=%b alu=%h want 000 0",
               {busy, done, invalid}, ALUResult);
    end
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    nd = 0;
    for (int e = 0; e < 6; e++) begin
      @(posedge Clk);
      #1;
      if (done || busy) nd++;
    end
    total++;
    if (nd !== 0 || dut.myReg.register[5] !== 32'h0 || reg_diffs() !== 0) begin
      bad++;
      $display("FAIL abort_state act=%0d r5=%h diffs=%0d want 0 0 0",
               nd, dut.myReg.register[5], reg_diffs());
    end
  endtask

  task automatic test_imm();
    int lat, el;
    bit inv, ei;
    model(32'h2006FFFF, el, ei);
    run_instr(32'h2006FFFF, lat, inv);
`ifdef MIPS_MC_IMM_OPS_EN
    total++;
    if (inv !== 1'b0 || dut.myReg.register[6] !== 32'hFFFFFFFF) begin
      bad++;
      $display("FAIL addi got inv=%b r6=%h want inv=0 r6=ffffffff",
               inv, dut.myReg.register[6]);
    end
`else
    total++;
    if (inv !== 1'b1 || dut.myReg.register[6] !== 32'h0) begin
      bad++;
      $display("FAIL addi_off got inv=%b r6=%h want inv=1 r6=0",
               inv, dut.myReg.register[6]);
    end
`endif
    total++;
    if (lat !== el || inv !== ei || reg_diffs() !== 0) begin
      bad++;
      $display("FAIL imm_model lat=%0d inv=%b diffs=%0d want lat=%0d inv=%b",
               lat, inv, reg_diffs(), el, ei);
    end
  endtask

  task automatic test_random();
    int lat, el, k;
    bit inv, ei;
    logic [31:0] ins, v;
    logic [5:0] fns [7];
    logic [5:0] imo [3];
    fns[0] = 6'h20; fns[1] = 6'h22; fns[2] = 6'h24; fns[3] = 6'h25;
    fns[4] = 6'h27; fns[5] = 6'h2A; fns[6] = 6'h21;
    imo[0] = 6'h08; imo[1] = 6'h0C; imo[2] = 6'h0D;
    for (int i = 0; i < 256; i++) begin
      v = $urandom;
      dut.dmem[i] = v;
      mmem[i] = v;
    end
    for (int n = 0; n < 60; n++) begin
      k = $urandom_range(0, 9);
      ins = $urandom;
      ins[25:21] = 5'($urandom_range(0, 7));
      ins[20:16] = 5'($urandom_range(0, 7));
      ins[15:11] = 5'($urandom_range(0, 7));
      if (k < 3) ins[31:26] = 6'h23;
      else if (k == 3) ins[31:26] = 6'h2B;
      else if (k < 8) begin
        ins[31:26] = 6'h00;
        ins[5:0] = fns[$urandom_range(0, 6)];
      end else if (k == 8) ins[31:26] = imo[$urandom_range(0, 2)];
      model(ins, el, ei);
      run_instr(ins, lat, inv);
      total++;
      if (lat !== el || inv !== ei) begin
        bad++;
        $display("FAIL rnd_timing ins=%h lat=%0d inv=%b want %0d %b",
                 ins, lat, inv, el, ei);
      end
      total++;
      if (reg_diffs() !== 0 || ALUResult !== malu) begin
        bad++;
        $display("FAIL rnd_state ins=%h diffs=%0d alu=%h want alu=%h",
                 ins, reg_diffs(), ALUResult, malu);
      end
    end
    total++;
    if (mem_diffs() !== 0) begin
      bad++;
      $display("FAIL rnd_mem diffs=%0d want 0", mem_diffs());
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_rtype();
    test_sw();
    test_r0_invalid();
    test_ignore();
    test_back_to_back();
    test_reset_abort();
    test_imm();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_mc_cpu.md
# mips_mc_cpu

Parametrised multi-cycle MIPS execution core, the next generation of the single-instruction `mipscpu`. It accepts one externally supplied instruction word per `newInstr` strobe and sequences it through decode, execute, memory and write-back states. It reports progress through a `busy`/`done` handshake and an `invalid` flag. It owns its register file (sub-module) and a word-addressed data memory array, and sits directly under the CPU testbench.

## Interface
- `DATA_W`, 32: datapath, register and memory word width; must be ≥ 16.
- `REG_N`, 32: number of architectural registers; power of 2, ≤ 32. Register index = low log2(REG_N) bits of the rs/rt/rd fields.
- `DMEM_DEPTH`, 256: data memory words; power of 2.
- `Clk`, in, 1: clock, rising edge.
- `Reset`, in, 1: asynchronous, active-high reset.
- `instrWord`, in, 32: MIPS instruction word. Sampled only on acceptance.
- `newInstr`, in, 1: request strobe. Level-sampled in IDLE.
- `busy`, out, 1: high while an instruction is in flight (states DEC through WB).
- `done`, out, 1: one-cycle pulse after an instruction retires.
- `invalid`, out, 1: one-cycle pulse, coincident with `done`, when the retired opcode/funct was unsupported.
- `ALUResult`, out, DATA_W: last EX-stage result. Held until the next EX.

## Operation
- Reset state:
  - FSM in IDLE.
  - `busy`=0, `done`=0, `invalid`=0, `ALUResult`=0.
  - All registers cleared to 0.
  - Data memory is not reset; the bench preloads it hierarchically via `dmem[i]`.
- FSM states: IDLE, DEC, EX, MEM, WB.
  - IDLE → DEC: on any edge where `newInstr`=1. `instrWord` is latched into the IR at that edge.
  - DEC → EX: unconditional. Reads rs/rt and forms the immediate.
  - EX → MEM: for lw/sw. EX → WB: for all other instructions.
  - MEM → WB: unconditional.
  - WB → IDLE: unconditional.
- While not in IDLE, `newInstr` is ignored; the request is dropped, not queued.
- If `newInstr` is held high, a new instruction is accepted on every IDLE edge.
- R-type instructions (opcode 0x00), by funct:
  - add 0x20, sub 0x22, and 0x24, or 0x25, nor 0x27.
  - slt 0x2A: signed compare, result 1 or 0.
  - Result is written to rd in WB.
- lw (0x23): effective address = rs + sext(imm16). Word index = (addr >> 2) mod DMEM_DEPTH. Memory is read in MEM; rt is written in WB.
- sw (0x2B): same address computation. rt is written to memory at the MEM edge. No register write.
- Arithmetic wraps modulo 2^DATA_W; there is no overflow trap. sext is to DATA_W bits.
- Register 0 always reads 0. Writes to register 0 are discarded.
- Any unsupported opcode or funct:
  - Passes through EX → WB with no register or memory write.
  - `invalid` pulses together with `done`.
  - `ALUResult` is unchanged.
- Reset asserted mid-instruction aborts immediately. No pending write commits, and all reset values apply.

## Timing
- Acceptance edge is E0. Then DEC = E0→E1, EX = E1→E2, WB/MEM follow.
- R-type / invalid: register write at E3; `done` high for the cycle E3→E4. Latency is 4 edges from acceptance to the `done` deassert edge.
- lw/sw: MEM at E2→E3, write at E4, `done` high for E4→E5.
- `done` coincides with IDLE. A `newInstr` sampled at the edge that ends `done` is accepted; back-to-back issue has no bubble.
- `ALUResult` updates at E2.

## Configuration
- `MIPS_MC_IMM_OPS_EN` defined: also supports the following, each writing rt in WB with no MEM state:
  - addi 0x08: sign-extended immediate.
  - andi 0x0C and ori 0x0D: zero-extended immediate.
- Undefined: opcodes 0x08, 0x0C and 0x0D are unsupported and raise `invalid`.

## Structure
- Shared package `mips_pkg`:
  - opcode and funct localparams.
  - FSM state enum.
  - ALU-op enum.
  - `sext16` function.
- Sub-module `mips_mc_regfile`:
  - parameters DATA_W, REG_N.
  - 2 asynchronous read ports, 1 synchronous write port.
  - asynchronous clear; r0 hardwired to 0.
  - array named `register`.
  - instance name `myReg`.
- Data memory: array `dmem` inside the top level. The ALU is inline.

## Test plan
- Preload dmem[0]=10, dmem[1]=22, dmem[2]=6. Issue lw r1,0(r0) (0x8C010000) → `done` at E4; r1=10, `ALUResult`=0.
- With r1=10, r2=22 loaded via lw, issue sub r3,r1,r2 (0x00221822) → r3=0xFFFFFFF4. Then slt r4,r1,r2 → r4=1. Each `done` arrives at E3.
- Issue sw r1,8(r0) (0xAC010008) with r1=10 → dmem[2]=10 and no register changes.
- Issue add r0,r1,r1 → r0 reads 0. Issue opcode 0x3F → `invalid`=1 with `done`, and no state change.
- Pulse `newInstr` during EX of a lw → ignored, only one `done`. Hold `newInstr` high for 12 cycles with an add → 3 retirements, each 4 edges apart.
- Assert `Reset` at E2 of lw r5 → r5=0, `busy`=0 and no `done`. With `MIPS_MC_IMM_OPS_EN` defined, addi r6,r0,-1 → r6=0xFFFFFFFF; without it, `invalid` is raised.
